mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues one lw/sw request, stalls the pipeline until ack.
// Optional BUSY timeout with sticky error is built only when MEM_ACCESS_CTRL_TIMEOUT_EN is defined.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  control_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [31:0] memData_o,
    output logic        err_o
);

    localparam logic [3:0] CTL_LW  = 4'b0110;
    localparam logic [3:0] CTL_SW  = 4'b0111;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_is_mem;
    logic        w_latch;
    logic        w_capture;
    logic        w_timeout;
    logic        w_expired;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem_data;

    assign w_is_mem = (control_i == CTL_LW) || (control_i == CTL_SW);

    // State register; reset aborts any in-flight request
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and request/stall decode
    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_capture  = 1'b0;
        w_timeout  = 1'b0;
        stall_o    = 1'b0;
        dmem_req_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_mem) begin
                    stall_o = 1'b1;
                    w_latch = 1'b1;
                    w_next  = S_BUSY;
                end
            end
            S_BUSY: begin
                stall_o    = 1'b1;
                dmem_req_o = 1'b1;
                if (dmem_ack_i) begin
                    w_capture = ~r_we;
                    w_next    = S_DONE;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                // control_i ignored here so the stalled instruction is not reissued
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request payload and load-result registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_mem_data <= 32'd0;
        end else begin
            if (w_latch) begin
                r_we    <= (control_i == CTL_SW);
                r_addr  <= {ALUResult_i[31:2], 2'b00};
                r_wdata <= wdata_i;
            end
            if (w_capture) begin
                r_mem_data <= dmem_rdata_i;
            end else if (w_timeout) begin
                r_mem_data <= 32'd0;
            end
        end
    end

    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_wdata_o = r_wdata;
    assign memData_o    = r_mem_data;

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_err;
    logic       w_unused_bits;

    // Counts un-acknowledged BUSY cycles; cleared as each request starts
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            if (w_latch) begin
                r_cnt <= 8'd0;
            end else if ((r_state == S_BUSY) && !dmem_ack_i) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_expired     = (r_cnt == TO_LAST);
    assign err_o         = r_err;
    assign w_unused_bits = ^ALUResult_i[1:0];
`else
    logic w_unused_bits;

    assign w_expired     = 1'b0;
    assign err_o         = 1'b0;
    assign w_unused_bits = ^{ALUResult_i[1:0], TO_LAST};
`endif

endmodule
